// File: rtl/mem_wb_regfile.sv
// MEM/WB write-back stage and 32-entry register file with write-through read bypass.
// Clearing after reset is sequenced one entry per cycle; busy stalls the pipeline meanwhile.
module mem_wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] read_data_in,
  input  logic [DATA_W-1:0] reg_data_in,
  input  logic [DATA_W-1:0] pc_plus4_in,
  input  logic [ADDR_W-1:0] rd_in,
  input  logic [1:0]        mem_to_reg_in,
  input  logic              reg_write_in,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_en,
  output logic              busy,
  output logic [31:0]       wb_count
);

  // state | meaning
  // CLEAR | zeroing entry idx each cycle, pipeline stalled
  // RUN   | normal write-back and reads
  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  localparam int DEPTH = 2 ** ADDR_W;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [31:0]         wb_count_q, wb_count_d;
  logic [DATA_W-1:0]   regs_q [DEPTH];

  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [DATA_W-1:0]   wdata;

  always_comb begin
    wb_data = '0;
    unique case (mem_to_reg_in)
      2'd0:    wb_data = reg_data_in;
      2'd1:    wb_data = read_data_in;
      2'd2:    wb_data = pc_plus4_in;
      default: wb_data = '0;
    endcase
  end

  assign busy  = ~rst | (state_q == CLEAR);
  assign wb_en = reg_write_in & (rd_in != '0) & (mem_to_reg_in != 2'd3) & ~busy;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wb_count_d = wb_count_q;
    we         = 1'b0;
    waddr      = rd_in;
    wdata      = wb_data;
    case (state_q)
      CLEAR: begin
        we    = 1'b1;
        waddr = idx_q;
        wdata = '0;
        idx_d = idx_q + 1'b1;
        if (idx_q == ADDR_W'(DEPTH - 1)) state_d = RUN;
      end
      default: begin
        if (wb_en) begin
          we         = 1'b1;
          wb_count_d = wb_count_q + 32'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= CLEAR;
      idx_q      <= '0;
      wb_count_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wb_count_q <= wb_count_d;
    end
  end

  // Storage has no reset; the CLEAR sequence zeroes it through the single write port.
  always_ff @(posedge clk) begin
    if (rst && we) regs_q[waddr] <= wdata;
  end

  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (!busy) begin
      if (rs_addr == '0)                 rs_data = '0;
      else if (wb_en && rs_addr == rd_in) rs_data = wb_data;
      else                               rs_data = regs_q[rs_addr];
      if (rt_addr == '0)                 rt_data = '0;
      else if (wb_en && rt_addr == rd_in) rt_data = wb_data;
      else                               rt_data = regs_q[rt_addr];
    end
  end

  assign wb_count = wb_count_q;

endmodule

// File: doc/mem_wb_regfile.md
Name: mem_wb_regfile

Overview:
- Write-back end of the MEM/WB pipeline register.
- Consumes the latched MEM/WB fields, selects the write-back value, and commits it into a 32-entry general-purpose register file.
- Serves the two ID-stage read ports with same-cycle write-through bypass.
- Storage is a single-write-port RAM, so post-reset clearing is sequenced by a small FSM; the pipeline stalls on busy until clearing completes.

Parameters:
DATA_W, 32, register and data width
ADDR_W, 5, register index width (2**ADDR_W entries)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
read_data_in  in  DATA_W  memory load data from MEM/WB
reg_data_in  in  DATA_W  ALU result from MEM/WB
pc_plus4_in  in  DATA_W  link address from MEM/WB
rd_in  in  ADDR_W  destination register from MEM/WB
mem_to_reg_in  in  2  write-back select from MEM/WB
reg_write_in  in  1  write enable from MEM/WB
rs_addr  in  ADDR_W  read port A index
rt_addr  in  ADDR_W  read port B index
rs_data  out  DATA_W  read port A data
rt_data  out  DATA_W  read port B data
wb_data  out  DATA_W  selected write-back value, for the forwarding unit
wb_en  out  1  qualified write strobe, for the forwarding unit
busy  out  1  clear sequence in progress; pipeline must stall
wb_count  out  32  number of committed writes

Behaviour:
- Write-back select (combinational), driven by mem_to_reg_in:
  - 0 -> reg_data_in
  - 1 -> read_data_in
  - 2 -> pc_plus4_in
  - 3 -> reserved; wb_data = 0 and the write is suppressed
- wb_en = reg_write_in & (rd_in != 0) & (mem_to_reg_in != 3) & ~busy.
- FSM has two states, CLEAR and RUN, plus a clear index idx (ADDR_W bits).
- rst = 0 at any clock edge, including mid-operation or mid-clear:
  - state <= CLEAR, idx <= 0, wb_count <= 0.
  - The register array is not written that edge.
  - busy = 1 while rst = 0.
- CLEAR with rst = 1: each edge writes reg[idx] = 0 and sets idx <= idx + 1.
  - The edge that writes reg[2**ADDR_W - 1] moves to RUN.
  - busy = 1 throughout CLEAR, so it falls exactly 32 edges after reset release.
- RUN: on each edge with wb_en = 1, reg[rd_in] <= wb_data and wb_count <= wb_count + 1.
  - wb_count wraps from 0xFFFFFFFF to 0 silently.
- Register 0:
  - Never written in RUN.
  - Reads of index 0 always return 0, in every state.
- Reads (combinational):
  - Busy: rs_data and rt_data = 0.
  - Otherwise, if wb_en = 1 and rs_addr == rd_in, rs_data = wb_data (write-through bypass); else rs_data = reg[rs_addr]. rt_data follows the same rule.
  - Both ports may hit the bypass at once.
- Inputs arriving while busy = 1 are ignored: no write, no count.
- Writes to the same rd on consecutive cycles: the last write wins. The bypass always reflects the current-cycle write.
- Latency:
  - Write-back commits at the edge ending the cycle in which wb_en = 1.
  - The bypass gives zero-cycle visibility to same-cycle reads.
- Reset values:
  - wb_count = 0, busy = 1.
  - rs_data, rt_data, wb_en = 0.
  - wb_data follows its inputs combinationally; it is 0 only when mem_to_reg_in = 3.

Test Plan:
- Reset/clear:
  - Stimulus: hold rst = 0 for 3 cycles, release; preload random RAM contents via backdoor before reset.
  - Required: busy = 1 for exactly 32 edges after release; afterwards every rs_addr 0..31 reads 0 and wb_count = 0.
- Write-back select:
  - Stimulus: reg_write_in = 1, rd_in = 5, and in successive cycles mem_to_reg_in = 0/1/2 with reg_data_in = 0x11, read_data_in = 0x22, pc_plus4_in = 0x33.
  - Required: reg5 reads 0x11, then 0x22, then 0x33; wb_count = 3.
  - Then mem_to_reg_in = 3: reg5 stays 0x33 and wb_count stays 3.
- Bypass:
  - Stimulus: write rd_in = 7, value 0xDEADBEEF, while rs_addr = rt_addr = 7 in the same cycle.
  - Required: both ports show 0xDEADBEEF before the edge, and reg7 holds it after.
- r0 protection:
  - Stimulus: reg_write_in = 1, rd_in = 0, data 0xFFFFFFFF.
  - Required: wb_en = 0, rs_addr = 0 reads 0, wb_count is unchanged.
- Reset mid-operation:
  - Stimulus: after reg3 = 0xA5, assert rst = 0 for 1 cycle mid-stream with reg_write_in = 1.
  - Required: no write that edge; busy = 1 for 32 edges; reg3 reads 0 afterwards; wb_count = 0.
- Busy gating and wrap:
  - Stimulus: drive writes during CLEAR; separately, force wb_count = 0xFFFFFFFF and commit one write.
  - Required: writes during CLEAR are ignored; wb_count becomes 0.
